// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, its downstream consumer and instruction memory.
// StallCount exists only when FETCH_STALL_COUNT_EN is defined.
interface fetch_unit_if;
  logic        En;
  logic        Flush;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemValid;
  logic [31:0] Instruction;
  logic [31:0] NewPCAddress;
  logic        InstrValid;
`ifdef FETCH_STALL_COUNT_EN
  logic [15:0] StallCount;
`endif

  modport slave (
    input  En, Flush, BranchTarget, IMemData, IMemValid,
    output IMemReq, IMemAddr, Instruction, NewPCAddress, InstrValid
`ifdef FETCH_STALL_COUNT_EN
    , output StallCount
`endif
  );

  modport master (
    output En, Flush, BranchTarget, IMemData, IMemValid,
    input  IMemReq, IMemAddr, Instruction, NewPCAddress, InstrValid
`ifdef FETCH_STALL_COUNT_EN
    , input StallCount
`endif
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a one-entry output hold and flush redirect.
// Define FETCH_STALL_COUNT_EN to add the saturating StallCount output.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] pc_next;

  assign target  = bus.BranchTarget & ~32'd3;
  assign pc_next = pc + 32'd4;

  // A flushed request cannot be cancelled at the memory, so S_DISCARD keeps it alive until its response is swallowed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state            <= S_IDLE;
      pc               <= RESET_VECTOR;
      bus.IMemReq      <= 1'b0;
      bus.IMemAddr     <= RESET_VECTOR;
      bus.Instruction  <= 32'd0;
      bus.NewPCAddress <= 32'd0;
      bus.InstrValid   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state        <= S_WAIT;
          bus.IMemReq  <= 1'b1;
          bus.IMemAddr <= pc;
        end
        S_WAIT: begin
          if (bus.Flush) begin
            pc             <= target;
            bus.InstrValid <= 1'b0;
            if (bus.IMemValid) begin
              bus.IMemAddr <= target;
            end else begin
              state <= S_DISCARD;
            end
          end else if (bus.IMemValid) begin
            bus.Instruction  <= bus.IMemData;
            bus.NewPCAddress <= pc_next;
            bus.InstrValid   <= 1'b1;
            pc               <= pc_next;
            bus.IMemReq      <= 1'b0;
            state            <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.Flush) begin
            pc             <= target;
            bus.InstrValid <= 1'b0;
            bus.IMemReq    <= 1'b1;
            bus.IMemAddr   <= target;
            state          <= S_WAIT;
          end else if (bus.En) begin
            bus.InstrValid <= 1'b0;
            bus.IMemReq    <= 1'b1;
            bus.IMemAddr   <= pc;
            state          <= S_WAIT;
          end
        end
        S_DISCARD: begin
          if (bus.Flush) begin
            pc             <= target;
            bus.InstrValid <= 1'b0;
          end
          if (bus.IMemValid) begin
            bus.IMemAddr <= bus.Flush ? target : pc;
            state        <= S_WAIT;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bus.StallCount <= 16'd0;
    end else if (bus.InstrValid && !bus.En && (bus.StallCount != 16'hFFFF)) begin
      bus.StallCount <= bus.StallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-programmable memory model, directed scenarios and a random phase.
// Expected deliveries follow the architectural fetch stream: reset vector, +4 per accepted instruction, redirect on flush.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic Clk;
  logic Rst_n;

  fetch_unit_if bus();

  fetch_unit #(.RESET_VECTOR(RV)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          deliveries = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  int          mem_lat = 1;
  bit          rand_lat = 0;
  bit          inject_late = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Instruction memory contents: a bijective scramble of the word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[18:0], a[31:19]} ^ 32'h9E37_79B9;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic applyReset(input bit late);
    @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    bus.En = 1'b0;
    bus.Flush = 1'b0;
    bus.BranchTarget = 32'd0;
    rand_lat = 1'b0;
    #1;
    checkOutput("rst_req", bus.IMemReq, 0);
    checkOutput("rst_addr", bus.IMemAddr, RV);
    checkOutput("rst_instr", bus.Instruction, 0);
    checkOutput("rst_newpc", bus.NewPCAddress, 0);
    checkOutput("rst_valid", bus.InstrValid, 0);
    exp_q.delete();
    exp_q.push_back(RV);
    req_log.delete();
    deliveries = 0;
    tick(2);
    inject_late = late;
    Rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input bit en, input bit flush, input logic [31:0] tgt);
    bus.En = en;
    bus.Flush = flush;
    if (flush) begin
      bus.BranchTarget = tgt;
      exp_q.delete();
      exp_q.push_back(tgt & ~32'd3);
    end
  endtask

  task automatic waitDeliveries(input int n, input int budget, input string name);
    int c = 0;
    while (deliveries < n && c < budget) begin
      tick(1);
      c++;
    end
    checkOutput(name, deliveries >= n, 1);
  endtask

  task automatic waitReqs(input int n, input int budget, input string name);
    int c = 0;
    while (req_log.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    checkOutput(name, req_log.size() >= n, 1);
  endtask

  // Memory model: one request at a time, fixed or random latency, one-cycle response strobe.
  initial begin
    bit          busy;
    int          cnt;
    logic [31:0] addr;
    busy = 1'b0;
    cnt = 0;
    addr = 32'd0;
    bus.IMemValid = 1'b0;
    bus.IMemData = 32'd0;
    forever begin
      @(posedge Clk);
      #2;
      if (!Rst_n) begin
        busy = 1'b0;
        bus.IMemValid = 1'b0;
      end else begin
        if (bus.IMemValid) begin
          bus.IMemValid = 1'b0;
          busy = 1'b0;
        end
        if (inject_late) begin
          inject_late = 1'b0;
          bus.IMemValid = 1'b1;
          bus.IMemData = 32'hBAD0_BAD0;
        end else if (busy) begin
          checkOutput("req_held", bus.IMemReq, 1);
          checkOutput("req_addr_stable", bus.IMemAddr, addr);
          cnt--;
          if (cnt == 0) begin
            bus.IMemValid = 1'b1;
            bus.IMemData = memWord(addr);
          end
        end else if (bus.IMemReq) begin
          busy = 1'b1;
          addr = bus.IMemAddr;
          cnt = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
          req_log.push_back(addr);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted instruction and checks that stalled outputs hold.
  initial begin
    logic [31:0] e;
    logic [31:0] prev_instr;
    logic [31:0] prev_newpc;
    bit          have_prev;
    logic [15:0] stall_model;
    have_prev = 1'b0;
    stall_model = 16'd0;
    prev_instr = 32'd0;
    prev_newpc = 32'd0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        have_prev = 1'b0;
        stall_model = 16'd0;
      end else begin
`ifdef FETCH_STALL_COUNT_EN
        checkOutput("stall_count_track", bus.StallCount, stall_model);
        if (bus.InstrValid && !bus.En && stall_model != 16'hFFFF) stall_model++;
`endif
        if (have_prev) begin
          checkOutput("hold_valid", bus.InstrValid, 1);
          checkOutput("hold_instr", bus.Instruction, prev_instr);
          checkOutput("hold_newpc", bus.NewPCAddress, prev_newpc);
        end
        have_prev = 1'b0;
        if (bus.InstrValid) begin
          checkOutput("hold_req_low", bus.IMemReq, 0);
          if (!bus.Flush && bus.En) begin
            if (exp_q.size() == 0) begin
              checkOutput("sb_unexpected_delivery", 1, 0);
            end else begin
              e = exp_q.pop_front();
              checkOutput("sb_instr", bus.Instruction, memWord(e));
              checkOutput("sb_newpc", bus.NewPCAddress, e + 32'd4);
              exp_q.push_back(e + 32'd4);
              deliveries++;
            end
          end else if (!bus.Flush) begin
            have_prev = 1'b1;
            prev_instr = bus.Instruction;
            prev_newpc = bus.NewPCAddress;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    int          c;
    Rst_n = 1'b1;
    bus.En = 1'b0;
    bus.Flush = 1'b0;
    bus.BranchTarget = 32'd0;

    $display("[TB] sequential fetch, 1-cycle memory");
    applyReset(0);
    mem_lat = 1;
    applyStimulus(1, 0, 32'd0);
    waitDeliveries(3, 40, "seq_deliveries");
    waitReqs(3, 10, "seq_reqs");
    checkOutput("seq_addr0", req_log[0], RV);
    checkOutput("seq_addr1", req_log[1], RV + 32'd4);
    checkOutput("seq_addr2", req_log[2], RV + 32'd8);

    $display("[TB] downstream stall for 5 cycles");
    applyReset(0);
    mem_lat = 2;
    applyStimulus(0, 0, 32'd0);
    c = 0;
    while (!bus.InstrValid && c < 20) begin
      tick(1);
      c++;
    end
    checkOutput("stall_valid_rise", bus.InstrValid, 1);
    tick(5);
    checkOutput("stall_instr", bus.Instruction, memWord(RV));
    checkOutput("stall_newpc", bus.NewPCAddress, RV + 32'd4);
    checkOutput("stall_req", bus.IMemReq, 0);
    checkOutput("stall_valid", bus.InstrValid, 1);
`ifdef FETCH_STALL_COUNT_EN
    checkOutput("stall_count", bus.StallCount, 5);
`endif
    applyStimulus(1, 0, 32'd0);
    waitDeliveries(1, 10, "stall_release");

    $display("[TB] flush while waiting, latency 3");
    applyReset(0);
    mem_lat = 3;
    applyStimulus(1, 0, 32'd0);
    tick(1);
    checkOutput("disc_req", bus.IMemReq, 1);
    applyStimulus(1, 1, 32'h0000_0100);
    tick(1);
    applyStimulus(1, 0, 32'd0);
    checkOutput("disc_req_old_addr", bus.IMemAddr, RV);
    waitDeliveries(1, 30, "disc_delivery");
    waitReqs(2, 10, "disc_reqs");
    checkOutput("disc_next_addr", req_log[1], 32'h0000_0100);

    $display("[TB] flush on the response edge");
    applyReset(0);
    mem_lat = 2;
    applyStimulus(1, 0, 32'd0);
    tick(3);
    applyStimulus(1, 1, 32'h0000_0203);
    tick(1);
    applyStimulus(1, 0, 32'd0);
    checkOutput("same_valid_low", bus.InstrValid, 0);
    checkOutput("same_req", bus.IMemReq, 1);
    checkOutput("same_req_addr", bus.IMemAddr, 32'h0000_0200);
    waitDeliveries(1, 20, "same_delivery");

    $display("[TB] PC wrap at top of address space");
    applyReset(0);
    mem_lat = 1;
    applyStimulus(1, 0, 32'd0);
    tick(1);
    applyStimulus(1, 1, 32'hFFFF_FFF8);
    tick(1);
    applyStimulus(1, 0, 32'd0);
    waitDeliveries(3, 40, "wrap_deliveries");
    waitReqs(4, 10, "wrap_reqs");
    checkOutput("wrap_next_addr", req_log[3], 32'h0000_0000);

    $display("[TB] reset mid-request with late response");
    applyReset(0);
    mem_lat = 3;
    applyStimulus(1, 0, 32'd0);
    tick(2);
    applyReset(1);
    bus.En = 1'b1;
    tick(1);
    checkOutput("late_valid_low", bus.InstrValid, 0);
    checkOutput("late_req", bus.IMemReq, 1);
    checkOutput("late_addr", bus.IMemAddr, RV);
    waitDeliveries(1, 20, "late_delivery");
    checkOutput("late_first_req", req_log[0], RV);

    $display("[TB] random traffic");
    applyReset(0);
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i >= 2 && $urandom_range(0, 11) == 0) begin
        tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        applyStimulus($urandom_range(0, 3) != 0, 1, tgt);
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, 0, 32'd0);
      end
      tick(1);
    end
    applyStimulus(1, 0, 32'd0);
    tick(10);
    checkOutput("random_progress", deliveries > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC loaded on reset (bits [1:0] SHALL be 00).
REQ-002 SHALL have port Clk  input  1  single clock; all sequential logic on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port En  input  1  downstream accept: 1 takes the presented instruction, 0 stalls.
REQ-005 SHALL have port Flush  input  1  redirect request: discard the held or in-flight fetch.
REQ-006 SHALL have port BranchTarget  input  32  redirect PC; bits [1:0] forced to 00.
REQ-007 SHALL have port IMemReq  output  1  instruction-memory request, level-held until response.
REQ-008 SHALL have port IMemAddr  output  32  fetch address, stable while IMemReq=1.
REQ-009 SHALL have port IMemData  input  32  fetched instruction word.
REQ-010 SHALL have port IMemValid  input  1  one-cycle response strobe; earliest the cycle after IMemReq rises.
REQ-011 SHALL have port Instruction  output  32  instruction presented downstream.
REQ-012 SHALL have port NewPCAddress  output  32  fetch address of Instruction plus 4.
REQ-013 SHALL have port InstrValid  output  1  Instruction/NewPCAddress valid.

Function
REQ-014 SHALL implement FSM states S_IDLE, S_WAIT, S_HOLD, S_DISCARD, with at most one outstanding request.
REQ-015 S_IDLE SHALL go to S_WAIT on the first edge after Rst_n release; IMemReq=0 in S_IDLE.
REQ-016 S_WAIT SHALL drive IMemReq=1, IMemAddr=PC.
REQ-017 S_WAIT with IMemValid=1 and Flush=0 SHALL capture Instruction<=IMemData, NewPCAddress<=PC+4, InstrValid<=1, PC<=PC+4, then go to S_HOLD.
REQ-018 S_HOLD SHALL drive IMemReq=0 and hold Instruction, NewPCAddress and InstrValid stable while En=0.
REQ-019 A transfer SHALL occur on an edge with InstrValid=1 and En=1: InstrValid<=0, next state S_WAIT.
REQ-020 Minimum fetch-to-fetch spacing SHALL be memory latency plus 2 cycles.
REQ-021 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 yields 32'h0000_0000.
REQ-022 Flush=1 SHALL override En: InstrValid<=0 and PC<=BranchTarget on that edge, in every state except S_IDLE.
REQ-023 Flush in S_WAIT with IMemValid=0 SHALL go to S_DISCARD.
REQ-024 Flush in S_WAIT with IMemValid=1 SHALL drop the data and stay in S_WAIT, requesting BranchTarget next cycle.
REQ-025 Flush in S_HOLD SHALL go to S_WAIT.
REQ-026 S_DISCARD SHALL keep IMemReq=1 with the old address, drop the response, and go to S_WAIT on IMemValid=1.
REQ-027 Flush in S_DISCARD SHALL update PC to the newest BranchTarget and go to S_WAIT if IMemValid=1, else stay.
REQ-028 IMemValid SHALL be ignored in S_IDLE and S_HOLD.

Reset
REQ-029 Rst_n=0 SHALL immediately force state S_IDLE, PC=RESET_VECTOR, IMemReq=0, IMemAddr=RESET_VECTOR, Instruction=0, NewPCAddress=0, InstrValid=0.
REQ-030 Reset mid-request SHALL abandon the outstanding fetch; a late IMemValid after release SHALL be ignored in S_IDLE.

Configuration
REQ-031 Macro FETCH_STALL_COUNT_EN defined SHALL add output StallCount (16 bits): +1 each cycle InstrValid=1 and En=0, saturating at 16'hFFFF, reset to 0.
REQ-032 Without FETCH_STALL_COUNT_EN, StallCount and its logic SHALL be absent.

Verification
REQ-033 Reset release, 1-cycle memory, En=1 -> IMemAddr sequence 0,4,8; Instruction matches IMemData; NewPCAddress 4,8,12.
REQ-034 En=0 for 5 cycles while InstrValid=1 -> Instruction/NewPCAddress stable, IMemReq=0; with macro, StallCount=5.
REQ-035 Flush with BranchTarget=32'h100 while S_WAIT and latency 3 -> stale response dropped; next IMemAddr=32'h100; no stale InstrValid.
REQ-036 Flush and IMemValid on the same edge -> data dropped; next request at BranchTarget; InstrValid stays 0.
REQ-037 PC at 32'hFFFF_FFFC fetched -> NewPCAddress=0; next IMemAddr=0.
REQ-038 Rst_n low mid-S_WAIT, then late IMemValid after release -> outputs at reset values; first request at RESET_VECTOR.
